// File: rtl/out_buffer.sv
// out_buffer: transmit side of the DMA path. Incoming result bytes are packed
// four per 32-bit word into block RAM. Once the last byte of a frame arrives,
// the buffered frame is streamed out as an AXI4-Stream master.
// Build option: define OUT_BUFFER_TRAILER_EN to append one trailer word
// {flags[7:0], byte_count[23:0]} after the final data word.
module out_buffer #(
  parameter int DEPTH_WORDS = 12544,
  parameter int PTR_W       = 14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_overflow,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tstrb,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH_WORDS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH_WORDS);
  localparam logic [PTR_W:0]   ONE_ITEM  = (PTR_W+1)'(1);
  localparam logic [PTR_W+1:0] ONE_BYTE  = (PTR_W+2)'(1);

  state_t state_q, state_d;

  // Collection side
  logic [PTR_W+1:0] byte_cnt;
  logic [31:0]      word_buf;
  logic [31:0]      pack;
  logic [1:0]       lane;
  logic [3:0]       lane_strb;
  logic [PTR_W-1:0] wr_addr;
  logic             full_q;
  logic             overflow_q;
  logic [PTR_W:0]   num_words;
  logic [3:0]       last_strb;
  logic             accept;
  logic             drop;
  logic             store;

  // Buffer storage and registered read port
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_q;

  // Read issue / prefetch side
  logic [PTR_W:0] issue_idx;
  logic [PTR_W:0] num_items;
  logic [2:0]     occ;
  logic           issue;
  logic           rd_en;
  logic           issue_last;
  logic [3:0]     issue_strb;
  logic           rd_pend;
  logic           pend_last;
  logic [3:0]     pend_strb;
  logic [31:0]    push_data;
`ifdef OUT_BUFFER_TRAILER_EN
  logic           issue_trailer;
  logic           pend_trailer;
`endif

  // Two-entry output skid buffer
  logic [31:0] fifo_data [2];
  logic [3:0]  fifo_strb [2];
  logic [1:0]  fifo_last;
  logic        wr_idx;
  logic        rd_idx;
  logic [1:0]  fifo_cnt;
  logic        pop;
  logic        frame_done;

  assign o_ready       = (state_q != SEND);
  assign o_overflow    = overflow_q;
  assign accept        = i_valid && o_ready;
  assign drop          = accept && full_q;
  assign store         = accept && !full_q && ((lane == 2'd3) || i_last);

  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_axis_tdata  = fifo_data[rd_idx];
  assign m_axis_tstrb  = fifo_strb[rd_idx];
  assign m_axis_tlast  = fifo_last[rd_idx];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign frame_done    = pop && m_axis_tlast;

  // Merge the incoming byte into its lane; lanes above it stay zero
  always_comb begin
    lane      = byte_cnt[1:0];
    wr_addr   = byte_cnt[PTR_W+1:2];
    pack      = word_buf;
    lane_strb = 4'hF;
    case (lane)
      2'd0: begin pack[7:0]   = i_data; lane_strb = 4'b0001; end
      2'd1: begin pack[15:8]  = i_data; lane_strb = 4'b0011; end
      2'd2: begin pack[23:16] = i_data; lane_strb = 4'b0111; end
      default: begin pack[31:24] = i_data; lane_strb = 4'b1111; end
    endcase
  end

  // Next-state logic for the collect/send sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = i_last ? SEND : COLLECT;
      COLLECT: if (accept && i_last) state_d = SEND;
      SEND:    if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Byte counting, word assembly, full/overflow tracking and end-of-frame capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt   <= '0;
      word_buf   <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      num_words  <= '0;
      last_strb  <= 4'h0;
    end else if (frame_done) begin
      byte_cnt <= '0;
      word_buf <= '0;
      full_q   <= 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) overflow_q <= 1'b0;
      if (drop) begin
        overflow_q <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt + ONE_BYTE;
        word_buf <= store ? 32'h0 : pack;
        if (store && (lane == 2'd3) && (wr_addr == LAST_ADDR)) full_q <= 1'b1;
      end
      if (i_last) begin
        num_words <= full_q ? DEPTH_CNT : ({1'b0, wr_addr} + ONE_ITEM);
        last_strb <= full_q ? 4'hF : lane_strb;
      end
    end
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (store) mem[wr_addr] <= pack;
  end

  // Read scheduling: only issue when the skid buffer has room for the result
  always_comb begin
    num_items = num_words;
`ifdef OUT_BUFFER_TRAILER_EN
    num_items = num_words + ONE_ITEM;
`endif
    occ        = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    issue      = (state_q == SEND) && (issue_idx != num_items) && (occ < 3'd2);
    issue_last = (issue_idx == (num_items - ONE_ITEM));
    issue_strb = (issue_idx == (num_words - ONE_ITEM)) ? last_strb : 4'hF;
    rd_en      = issue;
`ifdef OUT_BUFFER_TRAILER_EN
    issue_trailer = (issue_idx == num_words);
    rd_en         = issue && !issue_trailer;
`endif
  end

  // Buffer read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (rd_en) mem_q <= mem[issue_idx[PTR_W-1:0]];
  end

  // Track the read in flight together with its strobe/last attributes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      issue_idx <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      pend_strb <= 4'h0;
`ifdef OUT_BUFFER_TRAILER_EN
      pend_trailer <= 1'b0;
`endif
    end else begin
      rd_pend <= issue;
      if (issue) begin
        issue_idx <= issue_idx + ONE_ITEM;
        pend_last <= issue_last;
        pend_strb <= issue_strb;
`ifdef OUT_BUFFER_TRAILER_EN
        pend_trailer <= issue_trailer;
`endif
      end
      if (frame_done) issue_idx <= '0;
    end
  end

  // Select the word entering the skid buffer
  always_comb begin
    push_data = mem_q;
`ifdef OUT_BUFFER_TRAILER_EN
    if (pend_trailer) push_data = {7'd0, overflow_q, 24'(byte_cnt)};
`endif
  end

  // Skid buffer: head entry drives the AXIS outputs and holds until accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fifo_data[0] <= 32'h0;
      fifo_data[1] <= 32'h0;
      fifo_strb[0] <= 4'h0;
      fifo_strb[1] <= 4'h0;
      fifo_last    <= 2'b00;
      wr_idx       <= 1'b0;
      rd_idx       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (rd_pend) begin
        fifo_data[wr_idx] <= push_data;
        fifo_strb[wr_idx] <= pend_strb;
        fifo_last[wr_idx] <= pend_last;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({rd_pend, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
